// File: rtl/ddr_line_fetcher.sv
// DDR3 user-interface initiator: icache line fills as beat reads,
// plus single-beat preload writes. One line in flight at a time.
module ddr_line_fetcher #(
    parameter int LINE_BEATS      = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 28,
    localparam int BW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill_req_valid,
    output logic              fill_req_ready,
    input  logic [ADDR_W-1:0] fill_req_addr,
    output logic              fill_rsp_valid,
    output logic [127:0]      fill_rsp_data,
    output logic [BW-1:0]     fill_rsp_beat,
    output logic              fill_rsp_last,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [127:0]      wr_req_data,
    input  logic [15:0]       wr_req_mask,
    output logic              busy,
    output logic              err_unexpected_rd,
    input  logic              ddr_calib_done,
    input  logic              ddr_cmd_ready,
    output logic [2:0]        ddr_cmd,
    output logic              ddr_cmd_en,
    output logic [27:0]       ddr_addr,
    output logic [127:0]      ddr_wr_data,
    output logic [15:0]       ddr_wr_data_mask,
    output logic              ddr_wr_data_en,
    input  logic [127:0]      ddr_rd_data,
    input  logic              ddr_rd_data_valid
);

    localparam int OW = (MAX_OUTSTANDING > 0) ? $clog2(MAX_OUTSTANDING + 1) : 1;
    localparam int LB = $clog2(LINE_BEATS * 16);
    localparam logic [BW-1:0] LAST_IDX = BW'(LINE_BEATS - 1);
    localparam logic [OW-1:0] MAX_OS   = OW'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_CALIB,
        S_IDLE,
        S_WR_ISSUE,
        S_RD_ISSUE,
        S_RD_DRAIN
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [127:0]      wr_data_q;
    logic [15:0]       wr_mask_q;
    logic [BW-1:0]     issue_idx;
    logic [BW-1:0]     ret_idx;
    logic [OW-1:0]     outstanding;
    logic [ADDR_W-1:0] rd_addr;
    logic              fill_take;
    logic              wr_take;
    logic              rd_fire;
    logic              rd_ret;
    logic              rd_spurious;
    logic              unused_ok;

    assign unused_ok   = ^{fill_req_addr[LB-1:0], wr_req_addr[3:0]};
    assign rd_addr     = line_base + (ADDR_W'(issue_idx) << 4);
    assign fill_take   = fill_req_valid & fill_req_ready;
    assign wr_take     = wr_req_valid & wr_req_ready;
    assign rd_fire     = (state == S_RD_ISSUE) & ddr_cmd_en & ddr_cmd_ready;
    assign rd_ret      = ddr_rd_data_valid & (outstanding != '0);
    assign rd_spurious = ddr_rd_data_valid & (outstanding == '0);
    assign busy        = (state != S_IDLE);

    // Next-state and command/handshake decode from registered state.
    always_comb begin
        state_nx         = state;
        fill_req_ready   = 1'b0;
        wr_req_ready     = 1'b0;
        ddr_cmd          = 3'b000;
        ddr_cmd_en       = 1'b0;
        ddr_addr         = '0;
        ddr_wr_data      = '0;
        ddr_wr_data_mask = '0;
        ddr_wr_data_en   = 1'b0;
        case (state)
            S_CALIB: begin
                if (ddr_calib_done) state_nx = S_IDLE;
            end
            S_IDLE: begin
                wr_req_ready   = 1'b1;
                fill_req_ready = ~wr_req_valid;
                if (wr_req_valid)        state_nx = S_WR_ISSUE;
                else if (fill_req_valid) state_nx = S_RD_ISSUE;
            end
            S_WR_ISSUE: begin
                ddr_cmd_en       = 1'b1;
                ddr_wr_data_en   = 1'b1;
                ddr_addr         = 28'(wr_addr_q);
                ddr_wr_data      = wr_data_q;
                ddr_wr_data_mask = wr_mask_q;
                if (ddr_cmd_ready) state_nx = S_IDLE;
            end
            S_RD_ISSUE: begin
                ddr_cmd    = 3'b001;
                ddr_cmd_en = (outstanding < MAX_OS);
                ddr_addr   = 28'(rd_addr);
                if (ddr_cmd_en && ddr_cmd_ready && issue_idx == LAST_IDX)
                    state_nx = S_RD_DRAIN;
            end
            S_RD_DRAIN: begin
                if (rd_ret && ret_idx == LAST_IDX) state_nx = S_IDLE;
            end
            default: state_nx = S_CALIB;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_CALIB;
        else        state <= state_nx;
    end

    // Request latches and per-line issue/return counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_base   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_mask_q   <= '0;
            issue_idx   <= '0;
            ret_idx     <= '0;
            outstanding <= '0;
        end else begin
            if (rd_fire) issue_idx <= issue_idx + 1'b1;
            if (rd_ret)  ret_idx   <= ret_idx + 1'b1;
            if (rd_fire && !rd_ret)      outstanding <= outstanding + 1'b1;
            else if (!rd_fire && rd_ret) outstanding <= outstanding - 1'b1;
            if (wr_take) begin
                wr_addr_q <= {wr_req_addr[ADDR_W-1:4], 4'b0000};
                wr_data_q <= wr_req_data;
                wr_mask_q <= wr_req_mask;
            end
            if (fill_take) begin
                line_base <= {fill_req_addr[ADDR_W-1:LB], {LB{1'b0}}};
                issue_idx <= '0;
                ret_idx   <= '0;
            end
        end
    end

    // Registered beat return path and sticky spurious-data flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_rsp_valid    <= 1'b0;
            fill_rsp_last     <= 1'b0;
            fill_rsp_data     <= '0;
            fill_rsp_beat     <= '0;
            err_unexpected_rd <= 1'b0;
        end else begin
            fill_rsp_valid <= rd_ret;
            fill_rsp_last  <= rd_ret & (ret_idx == LAST_IDX);
            if (rd_ret) begin
                fill_rsp_data <= ddr_rd_data;
                fill_rsp_beat <= ret_idx;
            end
            if (rd_spurious) err_unexpected_rd <= 1'b1;
        end
    end

endmodule
